// File: rtl/svc_rv_bench_mon.sv
// Benchmark lifecycle monitor: MMIO start/stop/exit control, cycle/instret/event
// counters with tear-free LO/HI reads, and a sticky watchdog timeout.
module svc_rv_bench_mon #(
    parameter int NUM_EV          = 4,
    parameter int CNT_W           = 48,
    parameter int WATCHDOG_CYCLES = 100_000_000,
    parameter int WD_W            = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              retire,
    input  logic [NUM_EV-1:0] ev,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [3:0]        rd_addr,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [7:0]        exit_code
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    localparam logic [3:0]      ADDR_CTRL = 4'd0;
    localparam logic [3:0]      ADDR_EXIT = 4'd1;
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WATCHDOG_CYCLES - 1);
    localparam bit              WD_EN     = (WATCHDOG_CYCLES != 0);

    state_t            state, state_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instret_cnt;
    logic [CNT_W-1:0]  ev_cnt [NUM_EV];

    logic [31:0]       snap_hi;
    logic [2:0]        snap_idx;
    logic              snap_valid;

    logic              active;
    logic              counting;
    logic              ctrl_wr, exit_wr;
    logic              do_start, do_stop, do_clear;
    logic              wd_fire;
    logic              is_idle;

    logic              sel_valid;
    logic [2:0]        sel_idx;
    logic [63:0]       sel_val;
    logic [31:0]       rd_data_nxt;

    logic              unused_wr_data;
    assign unused_wr_data = ^wr_data[31:8];

    // Writes only take effect while the run is still live (IDLE or RUN).
    assign active   = (state == ST_IDLE) || (state == ST_RUN);
    assign counting = (state == ST_RUN);
    assign ctrl_wr  = wr_en && active && (wr_addr == ADDR_CTRL);
    assign exit_wr  = wr_en && active && (wr_addr == ADDR_EXIT);
    assign do_start = ctrl_wr && wr_data[0];
    assign do_stop  = ctrl_wr && wr_data[1];
    assign do_clear = ctrl_wr && wr_data[2];
    assign wd_fire  = WD_EN && active && (wd_cnt == WD_LAST);

    assign is_idle  = (state == ST_IDLE);
    assign running  = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign timeout  = (state == ST_TIMEOUT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (exit_wr)                  state_nxt = ST_DONE;
                else if (wd_fire)             state_nxt = ST_TIMEOUT;
                else if (do_start && !do_stop) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (exit_wr)      state_nxt = ST_DONE;
                else if (wd_fire) state_nxt = ST_TIMEOUT;
                else if (do_stop) state_nxt = ST_IDLE;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      wd_cnt <= '0;
        else if (active) wd_cnt <= wd_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       exit_code <= '0;
        else if (exit_wr) exit_code <= wr_data[7:0];
    end

    // Counting keys off the registered state, so the start cycle itself is not
    // counted while the stop cycle is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (do_clear) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (counting) begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            instret_cnt <= instret_cnt + CNT_W'(retire);
        end
    end

    // NOTE: the event counter array is architecturally visible state, so every
    // entry is reset rather than left as uninitialised storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_EV; i++) ev_cnt[i] <= '0;
        end else if (do_clear) begin
            for (int i = 0; i < NUM_EV; i++) ev_cnt[i] <= '0;
        end else if (counting) begin
            for (int i = 0; i < NUM_EV; i++) ev_cnt[i] <= ev_cnt[i] + CNT_W'(ev[i]);
        end
    end

    // Counter select: index 0 cycle, 1 instret, 2+i event i; value zero-extended to 64.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_val   = '0;
        if (rd_addr[3:1] == 3'd1) begin
            sel_valid = 1'b1;
            sel_idx   = 3'd0;
            sel_val   = 64'(cycle_cnt);
        end else if (rd_addr[3:1] == 3'd2) begin
            sel_valid = 1'b1;
            sel_idx   = 3'd1;
            sel_val   = 64'(instret_cnt);
        end else begin
            for (int i = 0; i < NUM_EV; i++) begin
                if (rd_addr[3:1] == 3'(4 + i)) begin
                    sel_valid = 1'b1;
                    sel_idx   = 3'(2 + i);
                    sel_val   = 64'(ev_cnt[i]);
                end
            end
        end
    end

    always_comb begin
        rd_data_nxt = '0;
        if (rd_addr == ADDR_CTRL) begin
            rd_data_nxt = {28'b0, timeout, done, running, is_idle};
        end else if (rd_addr == ADDR_EXIT) begin
            rd_data_nxt = {24'b0, exit_code};
        end else if (sel_valid) begin
            if (!rd_addr[0])                            rd_data_nxt = sel_val[31:0];
            else if (snap_valid && snap_idx == sel_idx) rd_data_nxt = snap_hi;
            else                                        rd_data_nxt = sel_val[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            snap_hi    <= '0;
            snap_idx   <= '0;
            snap_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_data_nxt;
                if (sel_valid && !rd_addr[0]) begin
                    snap_hi    <= sel_val[63:32];
                    snap_idx   <= sel_idx;
                    snap_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_svc_rv_bench_mon.sv
// Directed bench for svc_rv_bench_mon: reads are scored by a queue-driven
// monitor, state flags are checked inline after each control write.
module tb_svc_rv_bench_mon;

    localparam int NUM_EV = 3;
    localparam int CNT_W  = 48;
    localparam int WD_CYC = 1000;
    localparam int WD_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              retire = 1'b0;
    logic [NUM_EV-1:0] ev = '0;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic              rd_en = 1'b0;
    logic [3:0]        rd_addr = '0;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              running, done, timeout;
    logic [7:0]        exit_code;

    svc_rv_bench_mon #(
        .NUM_EV(NUM_EV), .CNT_W(CNT_W), .WATCHDOG_CYCLES(WD_CYC), .WD_W(WD_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .retire(retire), .ev(ev),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .running(running), .done(done), .timeout(timeout), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] want;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, want);
        end
    endtask

    // Monitor: every rd_valid pops one expected read response.
    always @(negedge clk) begin
        if (rd_valid) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=0x%08h required=no_response", rd_data);
            end else begin
                e = sb_q.pop_front();
                check(e.name, rd_data, e.want);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL sim_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        retire = 1'b0;
        ev = '0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] want, input string name);
        rd_en = 1'b1; rd_addr = a;
        sb_q.push_back('{name: name, want: want});
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr_rd(input logic [3:0] wa, input logic [31:0] d,
                         input logic [3:0] ra, input logic [31:0] want, input string name);
        wr_en = 1'b1; wr_addr = wa; wr_data = d;
        rd_en = 1'b1; rd_addr = ra;
        sb_q.push_back('{name: name, want: want});
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic flags(input string tag, input logic r, input logic d, input logic t);
        check({tag, "_running"}, {31'b0, running}, {31'b0, r});
        check({tag, "_done"},    {31'b0, done},    {31'b0, d});
        check({tag, "_timeout"}, {31'b0, timeout}, {31'b0, t});
    endtask

    initial begin
        // 1: reset state, 100 counted cycles, then idle hold
        do_reset();
        flags("rst", 1'b0, 1'b0, 1'b0);
        check("rst_exit_code", {24'b0, exit_code}, 32'h0);
        rd(4'd0, 32'h1, "rst_ctrl");
        rd(4'd2, 32'h0, "rst_cycle_lo");
        wr(4'd0, 32'h1);
        flags("t1_start", 1'b1, 1'b0, 1'b0);
        idle(99);
        wr(4'd0, 32'h2);
        flags("t1_stop", 1'b0, 1'b0, 1'b0);
        idle(20);
        rd(4'd2, 32'd100, "t1_cycle_lo");
        rd(4'd3, 32'd0,   "t1_cycle_hi");
        rd(4'd0, 32'h1,   "t1_ctrl_idle");

        // 2: retire every other cycle, 7 pulses on ev[2]
        do_reset();
        wr(4'd0, 32'h1);
        for (int i = 0; i < 50; i++) begin
            retire = (i % 2 == 0);
            ev[2]  = (i < 7);
            @(negedge clk);
        end
        retire = 1'b0;
        ev = '0;
        wr(4'd0, 32'h2);
        rd(4'd4,  32'd25, "t2_instret");
        rd(4'd12, 32'd7,  "t2_ev2");
        rd(4'd8,  32'd0,  "t2_ev0");
        rd(4'd2,  32'd51, "t2_cycle");
        rd(4'd14, 32'd0,  "t2_ev_absent");
        rd(4'd6,  32'd0,  "t2_reserved");

        // 3: LO/HI snapshot across the 2^32 boundary
        do_reset();
        force dut.cycle_cnt = 48'h1_FFFF_FFFE;
        force dut.instret_cnt = 48'h7_0000_0003;
        idle(1);
        rd(4'd2, 32'hFFFF_FFFE, "t3_cycle_lo");
        force dut.cycle_cnt = 48'h2_0000_0000;
        idle(1);
        rd(4'd3, 32'h1, "t3_cycle_hi_snap");
        rd(4'd5, 32'h7, "t3_instret_hi_live");
        rd(4'd2, 32'h0, "t3_cycle_lo2");
        rd(4'd3, 32'h2, "t3_cycle_hi2");
        release dut.cycle_cnt;
        release dut.instret_cnt;

        // 4: watchdog expiry, later EXIT ignored
        do_reset();
        idle(WD_CYC - 1);
        flags("t4_pre", 1'b0, 1'b0, 1'b0);
        idle(1);
        flags("t4_fire", 1'b0, 1'b0, 1'b1);
        wr(4'd1, 32'h55);
        flags("t4_exit", 1'b0, 1'b0, 1'b1);
        check("t4_exit_code", {24'b0, exit_code}, 32'h0);
        rd(4'd0, 32'h8, "t4_ctrl");

        // 5: EXIT during RUN freezes counters
        do_reset();
        wr(4'd0, 32'h1);
        idle(10);
        wr(4'd1, 32'h2A);
        flags("t5_exit", 1'b0, 1'b1, 1'b0);
        check("t5_exit_code", {24'b0, exit_code}, 32'h2A);
        idle(5);
        wr(4'd0, 32'h1);
        flags("t5_start", 1'b0, 1'b1, 1'b0);
        rd(4'd2, 32'd11, "t5_cycle");
        rd(4'd1, 32'h2A, "t5_exit_rd");
        rd(4'd0, 32'h4,  "t5_ctrl");

        // 6: clear|start mid-run with ev[0] high; read sees pre-write value
        do_reset();
        wr(4'd0, 32'h1);
        ev[0] = 1'b1;
        idle(9);
        wr_rd(4'd0, 32'h5, 4'd8, 32'd9, "t6_ev0_prewrite");
        flags("t6_clear", 1'b1, 1'b0, 1'b0);
        ev[0] = 1'b0;
        wr(4'd0, 32'h3);
        flags("t6_stop", 1'b0, 1'b0, 1'b0);
        rd(4'd2, 32'd1, "t6_cycle");
        rd(4'd8, 32'd0, "t6_ev0");
        wr(4'd0, 32'h3);
        flags("t6_startstop_idle", 1'b0, 1'b0, 1'b0);
        wr(4'd0, 32'h1);
        idle(5);
        do_reset();
        flags("t6_reset_midrun", 1'b0, 1'b0, 1'b0);
        rd(4'd2, 32'd0, "t6_cycle_after_reset");

        // 7: EXIT in the watchdog expiry cycle wins
        do_reset();
        idle(WD_CYC - 1);
        wr(4'd1, 32'h11);
        flags("t7_exit_wins", 1'b0, 1'b1, 1'b0);
        check("t7_exit_code", {24'b0, exit_code}, 32'h11);

        idle(3);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
